apb_slave_ctrl: RTL
===================

// Module: apb_slave_ctrl
// PURPOSE
//  APB slave protocol front-end placed directly upstream of the word storage block.
//  Decodes psel/penable phases, inserts programmable wait states and drives pready/pslverr.
//  Presents a clean one-cycle write-commit port to storage and returns read data.
//  Storage never sees a write outside the completing ACCESS cycle.
// PARAMETERS
//  ADDR_W       32          address width
//  DATA_W       32          data width; STRB_W = DATA_W/8
//  WAIT_STATES  0           extra ACCESS cycles with pready=0, legal 0..15
//  ADDR_LO      32'h0000_0000  lowest legal byte address (used only with APB_SLVERR_EN)
//  ADDR_HI      32'h0000_0FFC  highest legal byte address (used only with APB_SLVERR_EN)
// PORTS
//  pclk       in   1       clock; all state updates on rising edge
//  presetn    in   1       asynchronous active-low reset
//  psel       in   1       APB select
//  penable    in   1       APB access phase
//  pwrite     in   1       1=write, 0=read
//  paddr      in   ADDR_W  byte address
//  pwdata     in   DATA_W  write data
//  pstrb      in   STRB_W  byte strobes
//  pready     out  1       transfer completes this cycle
//  prdata     out  DATA_W  read data, valid only when pready & ~pwrite
//  pslverr    out  1       error response, valid only when pready
//  mem_we     out  1       single-cycle write commit to storage
//  mem_addr   out  ADDR_W  registered address to storage
//  mem_wdata  out  DATA_W  registered write data to storage
//  mem_strb   out  STRB_W  registered strobes, forwarded unchanged (4'b0000 = full word at storage)
//  mem_rdata  in   DATA_W  combinational read data from storage
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0; all outputs and capture registers are 0.
//  Reset is asynchronous, so an assertion mid-transfer drops mem_we/pready in the same cycle.
//  IDLE: psel & ~penable (SETUP phase) -> capture paddr/pwdata/pstrb/pwrite into mem_* regs;
//   cnt <= WAIT_STATES; go ACCESS. Otherwise stay in IDLE.
//  ACCESS with psel & penable:
//   cnt!=0 -> pready=0, cnt--.
//   cnt==0 -> pready=1 (combinational from state/cnt); mem_we = pwrite_q & ~err;
//    go IDLE at the clock edge.
//  ACCESS with ~psel -> abort to IDLE; no write, no pready.
//  ACCESS with psel & ~penable -> treated as a new SETUP: recapture all fields, reload cnt.
//  Back-to-back transfers: a SETUP in the cycle after completion is captured from IDLE
//   with no bubble.
//  Latency: WAIT_STATES+2 cycles per transfer (SETUP + ACCESS + wait states).
//  prdata = mem_rdata when pready & ~pwrite_q & ~err, else 0. pslverr = pready & err.
//  mem_we is never high for more than 1 cycle per transfer and never high outside ACCESS.
//  Counter width is $clog2(WAIT_STATES+1), minimum 1 bit.
// CONFIGURATION
//  Macro: APB_SLVERR_EN.
//  Defined: err is latched at SETUP and is set when paddr<ADDR_LO, paddr>ADDR_HI, or
//   paddr[1:0]!=0. An errored transfer still completes with pready and pslverr=1,
//   with mem_we suppressed and prdata=0.
//  Undefined: err=0 constant, pslverr tied 0, and every address is forwarded unchecked.
// STRUCTURE
//  Shared package apb_pkg: state enum {IDLE, ACCESS}, ADDR_W/DATA_W/STRB_W constants,
//   and the localparam for counter width.
//  One sub-module, apb_wait_counter: load/decrement/zero flag. FSM and decode stay in the top.
// TESTING
//  Write, WAIT_STATES=0: SETUP addr=0x10, data=0xDEADBEEF, strb=4'hF
//   -> next cycle pready=1, mem_we=1 with mem_addr=0x10; mem_we=0 after.
//  Read-back of 0x10 -> pready in the 2nd cycle, prdata=0xDEADBEEF, pslverr=0.
//  WAIT_STATES=3, read
//   -> pready low for exactly 3 ACCESS cycles, then high 1 cycle; total 5 cycles.
//  Back-to-back writes to 0x20 and 0x24 -> two mem_we pulses 2 cycles apart, no idle bubble.
//  Abort: psel drops in ACCESS with cnt=2 -> IDLE, mem_we never asserted, pready stays 0.
//  APB_SLVERR_EN, write to 0x1000 or to 0x13
//   -> pready=1, pslverr=1, mem_we=0, storage unchanged on read-back.
//  presetn pulsed low during ACCESS -> all outputs 0 immediately; next SETUP proceeds normally.

Source files
------------

// File: rtl/apb_slave_ctrl_pkg.sv
// Shared definitions for the APB slave front-end: bus widths, FSM state
// encoding, the wait-counter width rule and the address-range check.
package apb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam int WAIT_STATES_DEFAULT = 0;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Counter must hold WAIT_STATES; a zero-wait build still keeps one bit.
    function automatic int cnt_width(input int ws);
        int w;
        w = $clog2(ws + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W = cnt_width(WAIT_STATES_DEFAULT);

    // Out-of-window or non-word-aligned byte address.
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi);
        return (addr < lo) || (addr > hi) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/apb_slave_ctrl_if.sv
// APB bus bundle between a master and the apb_slave_ctrl front-end.
interface apb_slave_ctrl_if
    import apb_pkg::*;
    ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_slave_ctrl_wait_counter.sv
// Wait-state down-counter: load at SETUP, decrement through ACCESS,
// zero flag tells the FSM the transfer may complete.
module apb_wait_counter
    import apb_pkg::*;
#(
    parameter int CNT_W_P = 1
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               load,
    input  logic               dec,
    input  logic [CNT_W_P-1:0] load_val,
    output logic [CNT_W_P-1:0] cnt,
    output logic               zero
);

    logic [CNT_W_P-1:0] cnt_r;

    // Load takes priority over decrement; never wraps below zero.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_r <= {CNT_W_P{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {CNT_W_P{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W_P'(1);
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {CNT_W_P{1'b0}});

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave protocol front-end for the word storage block.
// Captures the SETUP phase, stretches ACCESS by WAIT_STATES cycles and
// issues a single-cycle write commit only in the completing ACCESS cycle.
// Optional macro APB_SLVERR_EN: adds the ADDR_LO/ADDR_HI parameters and
// flags out-of-window or misaligned addresses with pslverr (write dropped,
// read data zero). Without it every address is forwarded unchecked.
module apb_slave_ctrl
    import apb_pkg::*;
#(
`ifdef APB_SLVERR_EN
    parameter logic [ADDR_W-1:0] ADDR_LO = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_HI = 32'h0000_0FFC,
`endif
    parameter int WAIT_STATES = 0
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_slave_ctrl_if.slave   apb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_strb,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                CNT_W_L   = cnt_width(WAIT_STATES);
    localparam logic [CNT_W_L-1:0] WAIT_LOAD = CNT_W_L'(WAIT_STATES);

    apb_state_e        state_r;
    apb_state_e        next_state_s;
    logic              capture_s;
    logic              load_s;
    logic              dec_s;
    logic              pready_s;
    logic              cnt_zero_s;
    logic [CNT_W_L-1:0] cnt_s;
    logic              setup_err_s;
    logic [DATA_W-1:0] prdata_s;

    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic [STRB_W-1:0] mem_strb_r;
    logic              pwrite_r;
    logic              err_r;

    apb_wait_counter #(
        .CNT_W_P (CNT_W_L)
    ) u_wait_counter (
        .pclk     (pclk),
        .presetn  (presetn),
        .load     (load_s),
        .dec      (dec_s),
        .load_val (WAIT_LOAD),
        .cnt      (cnt_s),
        .zero     (cnt_zero_s)
    );

`ifdef APB_SLVERR_EN
    assign setup_err_s = addr_err(apb.paddr, ADDR_LO, ADDR_HI);
`else
    assign setup_err_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and phase decode; a SETUP seen in ACCESS restarts the transfer.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        load_s       = 1'b0;
        dec_s        = 1'b0;
        pready_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    capture_s    = 1'b1;
                    load_s       = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    next_state_s = IDLE;
                end else if (!apb.penable) begin
                    capture_s    = 1'b1;
                    load_s       = 1'b1;
                    next_state_s = ACCESS;
                end else if (!cnt_zero_s) begin
                    dec_s        = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    pready_s     = 1'b1;
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // SETUP-phase capture of the transfer fields and the address check.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_strb_r  <= {STRB_W{1'b0}};
            pwrite_r    <= 1'b0;
            err_r       <= 1'b0;
        end else if (capture_s) begin
            mem_addr_r  <= apb.paddr;
            mem_wdata_r <= apb.pwdata;
            mem_strb_r  <= apb.pstrb;
            pwrite_r    <= apb.pwrite;
            err_r       <= setup_err_s;
        end
    end

    // Read data is gated so the bus only shows storage data on a good read completion.
    always_comb begin
        prdata_s = {DATA_W{1'b0}};
        if (pready_s && !pwrite_r && !err_r) begin
            prdata_s = mem_rdata;
        end else begin
            prdata_s = {DATA_W{1'b0}};
        end
    end

    assign apb.pready  = pready_s;
    assign apb.pslverr = pready_s & err_r;
    assign apb.prdata  = prdata_s;

    assign mem_we    = pready_s & pwrite_r & ~err_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_strb  = mem_strb_r;

    logic unused_cnt_s;
    assign unused_cnt_s = ^cnt_s;

endmodule
